seg_monitor: RTL
================

# seg_monitor

Receive-side checker for the seven-segment output of the counter/display path. It samples the 7-bit segment bus, filters glitches, and decodes the pattern back to a 4-bit value. It classifies each change as an up-step, down-step or jump against a modulo-MOD count, and accumulates errors. It sits on the board next to the display driver, or in the bench as a self-checking monitor of the count path.

## Interface
- STABLE, 4: consecutive cycles a pattern must hold before acceptance; legal range 1..15
- MOD, 8: count modulus for step checking; legal range 2..16
- clk  in  1  system clock; all flops on rising edge
- rst  in  1  asynchronous, active-low reset
- seg  in  7  segment bus {g,f,e,d,c,b,a}, active-low (0 = segment lit)
- clr_err  in  1  synchronous clear of err_cnt
- value  out  4  last accepted decoded digit
- valid  out  1  value holds a legal tracked digit
- dir  out  2  last change: 00 hold/none, 01 up, 10 down, 11 jump
- step  out  1  one-cycle pulse on each accepted legal change
- step_err  out  1  one-cycle pulse on a jump
- illegal  out  1  one-cycle pulse on an accepted undecodable or out-of-range pattern
- err_cnt  out  8  saturating error count (jumps + illegals)

## Operation
- Decode table, gfedcba active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - blank=7F
  - all other codes are illegal.
- Input path: 2-flop synchronizer, then a candidate register and a 4-bit stability counter.
  - The counter restarts when the synchronized pattern differs from the candidate.
  - The candidate is accepted once it has been present for STABLE consecutive cycles.
  - The same pattern is accepted at most once; a new acceptance needs a pattern change.
- States: S_WAIT (no reference digit) and S_TRACK.
- On acceptance:
  - **Blank:** valid←0, state←S_WAIT, dir←00. No pulse, no error.
  - **Illegal code, or decoded digit ≥ MOD:** illegal pulse, err_cnt+1, valid←0, value held, state←S_WAIT.
  - **Legal digit d in S_WAIT:** value←d, valid←1, dir←00, state←S_TRACK. No step, no error.
  - **Legal digit d in S_TRACK, prev p:**
    - d = (p+1) mod MOD: dir←01, step pulse.
    - d = (p−1+MOD) mod MOD: dir←10, step pulse.
    - Otherwise: dir←11, step pulse, step_err pulse, err_cnt+1.
    - In every case value←d.
- Wrap-around: with MOD=8, 7→0 is up and 0→7 is down. With MOD=2, up takes precedence (dir=01).
- err_cnt saturates at 255.
- clr_err has priority. clr_err with a simultaneous error event gives err_cnt=1; clr_err alone gives 0.

## Timing
- Reset values:
  - value=0, valid=0, dir=00, step=step_err=illegal=0, err_cnt=0
  - state=S_WAIT
  - sync, candidate and last-accepted registers=7F
  - stability counter=0
- Reset mid-operation discards any partially-stable pattern.
- Latency: seg changes before edge k (the first edge sampling it). All outputs reflect the new pattern after edge k+STABLE+2.
- A pattern held for fewer than STABLE cycles at the synchronizer output is ignored and produces no output change.
- Pulses are high for exactly one cycle, aligned with the value/dir update.
- clr_err is sampled each edge and takes effect on that edge.

## Test plan
- **Reset and first lock:** reset, then seg=40 steady.
  - valid=0 until edge 6 (STABLE=4).
  - Then value=0, valid=1, dir=00, step=0, err_cnt=0.
- **Up sequence with wrap:** 0,1,…,7,0, each held 10 cycles (MOD=8).
  - 8 step pulses, all dir=01.
  - Last change (7→0) dir=01; err_cnt=0.
- **Down and jump:** 3→2→6.
  - 3→2 gives dir=10.
  - 2→6 gives dir=11, step_err pulse, err_cnt=1, value=6.
- **Glitch filter:** in track at 2, drive 30 for 3 cycles then back to 24.
  - No step, value stays 2.
  - Then hold 30 for 4 cycles: step, dir=01, value=3.
- **Illegal, out-of-range, blank:**
  - seg=55 gives illegal pulse, valid=0, err_cnt+1.
  - seg=00 (8, MOD=8) gives illegal.
  - seg=7F gives valid=0 with no error.
  - Next seg=19 relocks: value=4, dir=00.
- **Saturation, clear, reset mid-run:**
  - Force 300 jumps: err_cnt=255.
  - clr_err with a simultaneous jump: err_cnt=1.
  - Assert rst mid-stabilization: all outputs return to reset values, and the pending pattern is not accepted until it is stable again.

Source files
------------

// File: rtl/seg_monitor_if.sv
// seg_monitor_if: segment bus, error clear and decoded status between a display source and the monitor.
interface seg_monitor_if;
    logic [6:0] seg;
    logic       clr_err;
    logic [3:0] value;
    logic       valid;
    logic [1:0] dir;
    logic       step;
    logic       step_err;
    logic       illegal;
    logic [7:0] err_cnt;
    modport master (output seg, clr_err, input value, valid, dir, step, step_err, illegal, err_cnt);
    modport slave  (input seg, clr_err, output value, valid, dir, step, step_err, illegal, err_cnt);
endinterface

// File: rtl/seg_monitor.sv
// seg_monitor: filters and decodes an active-low seven-segment bus, classifies digit changes
// against a modulo-MOD count and accumulates a saturating error count.
module seg_monitor #(
    parameter int STABLE = 4,
    parameter int MOD    = 8
) (
    input logic clk,
    input logic rst_n,
    seg_monitor_if.slave bus
);
    typedef enum logic {S_WAIT, S_TRACK} state_t;
    localparam logic [4:0] M = 5'(MOD);
    localparam logic [3:0] S = 4'(STABLE);
    state_t     state;
    logic [6:0] s1, s2, cand, last;
    logic [3:0] cnt, d;
    logic [4:0] up_v, dn_v;
    logic       acc, blank, legal, bad, up, dn, jump, ev;
    always_comb begin
        legal = 1'b1;
        d = 4'h0;
        case (cand)
            7'h40: d = 4'h0;
            7'h79: d = 4'h1;
            7'h24: d = 4'h2;
            7'h30: d = 4'h3;
            7'h19: d = 4'h4;
            7'h12: d = 4'h5;
            7'h02: d = 4'h6;
            7'h78: d = 4'h7;
            7'h00: d = 4'h8;
            7'h10: d = 4'h9;
            7'h08: d = 4'hA;
            7'h03: d = 4'hB;
            7'h46: d = 4'hC;
            7'h21: d = 4'hD;
            7'h06: d = 4'hE;
            7'h0E: d = 4'hF;
            default: legal = 1'b0;
        endcase
        blank = cand == 7'h7F;
        bad   = legal ? {1'b0, d} >= M : !blank;
        acc   = cnt == S && cand != last;
        up_v  = ({1'b0, bus.value} + 5'd1 == M) ? 5'd0 : {1'b0, bus.value} + 5'd1;
        dn_v  = (bus.value == 4'h0) ? M - 5'd1 : {1'b0, bus.value} - 5'd1;
        up    = {1'b0, d} == up_v;
        dn    = {1'b0, d} == dn_v;
        jump  = acc && !blank && !bad && state == S_TRACK && !up && !dn;
        ev    = jump || (acc && bad);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 7'h7F;
            s2 <= 7'h7F;
            cand <= 7'h7F;
            last <= 7'h7F;
            cnt <= 4'h0;
            state <= S_WAIT;
            bus.value <= 4'h0;
            bus.valid <= 1'b0;
            bus.dir <= 2'b00;
            bus.step <= 1'b0;
            bus.step_err <= 1'b0;
            bus.illegal <= 1'b0;
            bus.err_cnt <= 8'h00;
        end else begin
            s1 <= bus.seg;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt <= 4'h1;
            end else if (cnt != S) begin
                cnt <= cnt + 4'h1;
            end
            bus.step <= 1'b0;
            bus.step_err <= 1'b0;
            bus.illegal <= 1'b0;
            bus.err_cnt <= bus.clr_err ? {7'h00, ev} : (ev && bus.err_cnt != 8'hFF) ? bus.err_cnt + 8'h01 : bus.err_cnt;
            if (acc) begin
                last <= cand;
                if (blank) begin
                    bus.valid <= 1'b0;
                    bus.dir <= 2'b00;
                    state <= S_WAIT;
                end else if (bad) begin
                    bus.illegal <= 1'b1;
                    bus.valid <= 1'b0;
                    state <= S_WAIT;
                end else if (state == S_WAIT) begin
                    bus.value <= d;
                    bus.valid <= 1'b1;
                    bus.dir <= 2'b00;
                    state <= S_TRACK;
                end else begin
                    bus.value <= d;
                    bus.step <= 1'b1;
                    bus.step_err <= jump;
                    bus.dir <= up ? 2'b01 : dn ? 2'b10 : 2'b11;
                end
            end
        end
    end
endmodule
